// File: rtl/multi_rate_divider.sv
// Multi-channel clock divider: per-channel programmable period, tick pulse,
// 50% toggle output, periodic or one-shot operation.
module multi_rate_divider #(
  parameter int WIDTH    = 28,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(833333)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] oneshot,
  input  logic [CHANNELS-1:0] start,
  input  logic                wr_en,
  input  logic [CH_BITS-1:0]  wr_chan,
  input  logic [WIDTH-1:0]    wr_period,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] armed
);

  logic [WIDTH-1:0]    p_q [CHANNELS];
  logic [WIDTH-1:0]    p_d [CHANNELS];
  logic [WIDTH-1:0]    q_q [CHANNELS];
  logic [WIDTH-1:0]    q_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] toggle_q, toggle_d;
  logic [CHANNELS-1:0] armed_q, armed_d;

  always_comb begin
    logic [WIDTH-1:0] p_eff;
    logic             run;
    for (int c = 0; c < CHANNELS; c++) begin
      // A write landing in a reload/start cycle is seen by that load.
      p_eff = (wr_en && (int'(wr_chan) == c)) ? wr_period : p_q[c];
      run   = enable[c] && (!oneshot[c] || armed_q[c]);

      p_d[c]      = p_eff;
      q_d[c]      = q_q[c];
      tick_d[c]   = 1'b0;
      toggle_d[c] = toggle_q[c];
      armed_d[c]  = armed_q[c];

      if (start[c]) begin
        q_d[c]     = p_eff;
        armed_d[c] = oneshot[c];
      end else if (run) begin
        if (q_q[c] == '0) begin
          q_d[c]      = p_eff;
          tick_d[c]   = 1'b1;
          toggle_d[c] = ~toggle_q[c];
          if (oneshot[c]) armed_d[c] = 1'b0;
        end else begin
          q_d[c] = q_q[c] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        p_q[c] <= DEFAULT_PERIOD;
        q_q[c] <= DEFAULT_PERIOD;
      end
      tick_q   <= '0;
      toggle_q <= '0;
      armed_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        p_q[c] <= p_d[c];
        q_q[c] <= q_d[c];
      end
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
      armed_q  <= armed_d;
    end
  end

  assign tick   = tick_q;
  assign toggle = toggle_q;
  assign armed  = armed_q;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Bench for multi_rate_divider: vector table, directed corner sequences
// and randomized traffic against a counting-cycle reference model.
module tb_multi_rate_divider;

  localparam int N   = 4;
  localparam int DEF = 833333;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enable, oneshot, start;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [27:0] wr_period;
  logic [3:0]  tick, toggle, armed;

  logic        reset2;
  logic [2:0]  en2, os2, st2, tick2, tog2, arm2;
  logic        wr_en2;
  logic [1:0]  wr_chan2;
  logic [7:0]  wr_per2;

  multi_rate_divider dut (
    .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot),
    .start(start), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_period(wr_period), .tick(tick), .toggle(toggle), .armed(armed)
  );

  multi_rate_divider #(
    .WIDTH(8), .CHANNELS(3), .CH_BITS(2), .DEFAULT_PERIOD(8'd4)
  ) dut2 (
    .clk(clk), .reset(reset2), .enable(en2), .oneshot(os2),
    .start(st2), .wr_en(wr_en2), .wr_chan(wr_chan2),
    .wr_period(wr_per2), .tick(tick2), .toggle(tog2), .armed(arm2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: counting cycles since the last load, compared against the
  // period captured at that load.
  int         mp[N], mper[N], mcnt[N];
  logic [3:0] mt, mtog, marm;

  typedef struct {
    logic [3:0] en, os, st;
    logic       we;
    int         wp;
    logic [3:0] t, tg, a;
  } vec_t;
  vec_t tbl[$];
  int   tq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        mp[c] = DEF; mper[c] = DEF; mcnt[c] = 0;
      end
      mt = '0; mtog = '0; marm = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        int pe;
        pe = (wr_en && int'(wr_chan) == c) ? int'(wr_period) : mp[c];
        if (start[c]) begin
          mper[c] = pe; mcnt[c] = 0; mt[c] = 1'b0; marm[c] = oneshot[c];
        end else if (enable[c] && (!oneshot[c] || marm[c])) begin
          mcnt[c]++;
          if (mcnt[c] == mper[c] + 1) begin
            mt[c] = 1'b1; mtog[c] = ~mtog[c];
            mper[c] = pe; mcnt[c] = 0;
            if (oneshot[c]) marm[c] = 1'b0;
          end else begin
            mt[c] = 1'b0;
          end
        end else begin
          mt[c] = 1'b0;
        end
        mp[c] = pe;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick",   int'(tick),   int'(mt));
    chk("toggle", int'(toggle), int'(mtog));
    chk("armed",  int'(armed),  int'(marm));
  endtask

  task automatic set_idle();
    reset = 1'b0; enable = '0; oneshot = '0; start = '0;
    wr_en = 1'b0; wr_chan = '0; wr_period = '0;
  endtask

  function automatic void add(bit en, bit os, bit st, bit we, int wp,
                              bit t, bit tg, bit a);
    tbl.push_back('{{3'b0, en}, {3'b0, os}, {3'b0, st}, we, wp,
                    {3'b0, t}, {3'b0, tg}, {3'b0, a}});
  endfunction

  initial begin
    int na, nt, n0, n1;
    set_idle();
    reset = 1'b1;

    // Out-of-range write on a 3-channel instance must not disturb anything.
    reset2 = 1'b1; en2 = 3'b111; os2 = '0; st2 = '0;
    wr_en2 = 1'b0; wr_chan2 = 2'd3; wr_per2 = 8'd1;
    @(posedge clk); #1;
    reset2 = 1'b0; wr_en2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("oor_tick", int'(tick2), (k % 5 == 0) ? 7 : 0);
      chk("oor_tog",  int'(tog2),  ((k / 5) % 2 == 1) ? 7 : 0);
    end
    wr_en2 = 1'b0;

    // Reset state
    cycle();
    for (int c = 0; c < N; c++) begin
      chk("rst_p", int'(dut.p_q[c]), DEF);
      chk("rst_q", int'(dut.q_q[c]), DEF);
    end
    reset = 1'b0;

    // Vector table, channel 0 only
    add(0,0,0,1,3, 0,0,0); add(1,0,1,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 1,1,0);
    add(1,0,0,0,0, 0,1,0); add(1,0,0,0,0, 0,1,0);
    add(1,0,0,0,0, 0,1,0); add(1,0,0,0,0, 1,0,0);
    add(0,0,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 1,1,0);
    add(1,1,1,1,2, 0,1,1); add(1,1,0,0,0, 0,1,1);
    add(1,1,0,0,0, 0,1,1); add(1,1,0,0,0, 1,0,0);
    add(1,1,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0);
    add(1,0,0,1,0, 0,0,0); add(1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 1,1,0); add(1,0,0,0,0, 1,0,0);
    add(1,0,0,0,0, 1,1,0); add(0,0,0,0,0, 0,1,0);
    foreach (tbl[i]) begin
      enable = tbl[i].en; oneshot = tbl[i].os; start = tbl[i].st;
      wr_en = tbl[i].we; wr_chan = 2'd0; wr_period = 28'(tbl[i].wp);
      cycle();
      chk($sformatf("vec%0d_tick", i), int'(tick),   int'(tbl[i].t));
      chk($sformatf("vec%0d_tog", i),  int'(toggle), int'(tbl[i].tg));
      chk($sformatf("vec%0d_arm", i),  int'(armed),  int'(tbl[i].a));
    end

    // Enable gating: 5 disabled cycles stretch a 4-cycle interval to 9
    set_idle();
    enable[2] = 1'b1; start[2] = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd2; wr_period = 28'd3;
    cycle();
    set_idle();
    tq.delete();
    for (int k = 1; k <= 14; k++) begin
      enable[2] = !(k >= 6 && k <= 10);
      cycle();
      if (tick[2]) tq.push_back(k);
    end
    chk("gate_first", tq.size() > 0 ? tq[0] : -1, 4);
    chk("gate_gap", tq.size() > 1 ? tq[1] - tq[0] : -1, 9);

    // Rewrite period mid-count: Q expires naturally, then new period
    set_idle();
    enable[1] = 1'b1; start[1] = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd1; wr_period = 28'd10;
    cycle();
    start = '0;
    tq.delete();
    for (int k = 1; k <= 18; k++) begin
      wr_en = (k == 7); wr_period = 28'd2;
      cycle();
      if (k == 6) chk("wr_q4", int'(dut.q_q[1]), 4);
      if (tick[1]) tq.push_back(k);
    end
    chk("wr_n", tq.size(), 3);
    chk("wr_t0", tq.size() > 0 ? tq[0] : -1, 11);
    chk("wr_t1", tq.size() > 1 ? tq[1] : -1, 14);
    chk("wr_t2", tq.size() > 2 ? tq[2] : -1, 17);

    // One-shot P=5
    set_idle();
    enable[3] = 1'b1; oneshot[3] = 1'b1; start[3] = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd3; wr_period = 28'd5;
    cycle();
    na = int'(armed[3]); nt = 0;
    start = '0; wr_en = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      na += int'(armed[3]);
      nt += int'(tick[3]);
      if (tick[3]) chk("os_time", k, 6);
    end
    chk("os_armed", na, 6);
    chk("os_ticks", nt, 1);
    start[3] = 1'b1;
    cycle();
    start = '0; nt = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      nt += int'(tick[3]);
    end
    chk("os_ticks2", nt, 1);

    // Two independent channels
    set_idle();
    wr_en = 1'b1; wr_chan = 2'd0; wr_period = 28'd2;
    cycle();
    wr_chan = 2'd1; wr_period = 28'd6;
    start = 4'b0011; enable = 4'b0011;
    cycle();
    start = '0; wr_en = 1'b0; n0 = 0; n1 = 0;
    for (int k = 1; k <= 21; k++) begin
      cycle();
      n0 += int'(tick[0]);
      n1 += int'(tick[1]);
    end
    chk("ind_ch0", n0, 7);
    chk("ind_ch1", n1, 3);

    // Reset while armed with toggle high
    set_idle();
    enable[3] = 1'b1; start[3] = 1'b1;
    wr_en = 1'b1; wr_chan = 2'd3; wr_period = 28'd1;
    cycle();
    set_idle(); enable[3] = 1'b1;
    cycle(); cycle();
    oneshot[3] = 1'b1; start[3] = 1'b1;
    cycle();
    chk("pre_arm", int'(armed[3]), 1);
    chk("pre_tog", int'(toggle[3]), 1);
    start = '0; reset = 1'b1;
    cycle();
    chk("mrst_tick", int'(tick), 0);
    chk("mrst_tog",  int'(toggle), 0);
    chk("mrst_arm",  int'(armed), 0);
    for (int c = 0; c < N; c++) begin
      chk("mrst_p", int'(dut.p_q[c]), DEF);
      chk("mrst_q", int'(dut.q_q[c]), DEF);
    end

    // Randomized traffic
    set_idle();
    for (int c = 0; c < N; c++) begin
      wr_en = 1'b1; wr_chan = 2'(c);
      wr_period = 28'($urandom_range(0, 5));
      start = '0; start[c] = 1'b1;
      cycle();
    end
    set_idle();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++) begin
        enable[c] = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 19) == 0) oneshot[c] = ~oneshot[c];
        start[c] = ($urandom_range(0, 29) == 0);
      end
      wr_en = ($urandom_range(0, 9) == 0);
      wr_chan = 2'($urandom_range(0, 3));
      wr_period = 28'($urandom_range(0, 6));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
